// File: rtl/trap_sequencer.sv
// trap_sequencer: central trap controller for the core.
// Picks one synchronous exception by fixed priority (source 0 highest),
// captures mepc/mcause/mtval, flushes the pipeline, waits for it to drain
// and redirects fetch to mtvec. An mret takes the same path towards mepc.
// Optional macro TRAP_SEQ_COUNT_EN adds a saturating accepted-trap counter;
// without it trap_count_o is tied to zero.
module trap_sequencer #(
    parameter int              XLEN        = 32,
    parameter int              NUM_SRC     = 4,
    parameter logic [XLEN-1:0] MTVEC_RESET = 'h100
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SRC-1:0]      exc_valid_i,
    input  logic [NUM_SRC*5-1:0]    exc_cause_i,
    input  logic [NUM_SRC*XLEN-1:0] exc_pc_i,
    input  logic [NUM_SRC*XLEN-1:0] exc_tval_i,
    input  logic                    mret_i,
    input  logic                    pipe_empty_i,
    input  logic                    redirect_ready_i,
    input  logic                    csr_we_i,
    input  logic [1:0]              csr_sel_i,
    input  logic [XLEN-1:0]         csr_wdata_i,
    output logic [NUM_SRC-1:0]      exc_ack_o,
    output logic                    flush_o,
    output logic                    redirect_valid_o,
    output logic [XLEN-1:0]         redirect_pc_o,
    output logic                    trap_busy_o,
    output logic [XLEN-1:0]         mtvec_o,
    output logic [XLEN-1:0]         mepc_o,
    output logic [XLEN-1:0]         mcause_o,
    output logic [XLEN-1:0]         mtval_o,
    output logic [31:0]             trap_count_o
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t state;

    logic [XLEN-1:0]    target;
    logic [XLEN-1:0]    mtvec;
    logic [XLEN-1:0]    mepc;
    logic [XLEN-1:0]    mcause;
    logic [XLEN-1:0]    mtval;

    logic               any_exc;
    logic               accept_exc;
    logic [NUM_SRC-1:0] win_onehot;
    logic [4:0]         win_cause;
    logic [XLEN-1:0]    win_pc;
    logic [XLEN-1:0]    win_tval;

    // Fixed-priority select: scanning downwards leaves the lowest set index as winner
    always_comb begin
        any_exc    = 1'b0;
        win_onehot = '0;
        win_cause  = '0;
        win_pc     = '0;
        win_tval   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (exc_valid_i[k]) begin
                any_exc       = 1'b1;
                win_onehot    = '0;
                win_onehot[k] = 1'b1;
                win_cause     = exc_cause_i[k*5 +: 5];
                win_pc        = exc_pc_i[k*XLEN +: XLEN];
                win_tval      = exc_tval_i[k*XLEN +: XLEN];
            end
        end
    end

    assign accept_exc = (state == IDLE) && any_exc;

    assign mtvec_o  = mtvec;
    assign mepc_o   = mepc;
    assign mcause_o = mcause;
    assign mtval_o  = mtval;

    // Trap FSM with CSR file; capture is written after the CSR write so it wins on a clash
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            exc_ack_o        <= '0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            trap_busy_o      <= 1'b0;
            target           <= '0;
            mtvec            <= MTVEC_RESET;
            mepc             <= '0;
            mcause           <= '0;
            mtval            <= '0;
        end else begin
            exc_ack_o <= '0;

            if (csr_we_i) begin
                case (csr_sel_i)
                    2'd0:    mtvec  <= {csr_wdata_i[XLEN-1:2], 2'b00};
                    2'd1:    mepc   <= csr_wdata_i;
                    2'd2:    mcause <= csr_wdata_i;
                    default: mtval  <= csr_wdata_i;
                endcase
            end

            case (state)
                IDLE: begin
                    if (accept_exc) begin
                        exc_ack_o   <= win_onehot;
                        mepc        <= win_pc;
                        mtval       <= win_tval;
                        mcause      <= {{(XLEN-5){1'b0}}, win_cause};
                        target      <= mtvec;
                        flush_o     <= 1'b1;
                        trap_busy_o <= 1'b1;
                        state       <= FLUSH;
                    end else if (mret_i) begin
                        target      <= mepc;
                        flush_o     <= 1'b1;
                        trap_busy_o <= 1'b1;
                        state       <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pipe_empty_i) begin
                        flush_o          <= 1'b0;
                        redirect_valid_o <= 1'b1;
                        redirect_pc_o    <= target;
                        state            <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        trap_busy_o      <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TRAP_SEQ_COUNT_EN
    logic [31:0] trap_count;

    // Saturating count of accepted exceptions; mret does not count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trap_count <= '0;
        end else if (accept_exc && (trap_count != 32'hFFFF_FFFF)) begin
            trap_count <= trap_count + 32'd1;
        end
    end

    assign trap_count_o = trap_count;
`else
    assign trap_count_o = 32'd0;
`endif

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Central trap controller for the core. Collects synchronous exception requests from several pipeline sources, such as the load/store misaligned checker, the illegal-instruction decoder and ecall/ebreak.
- Picks one request by fixed priority and latches mcause/mepc/mtval.
- Sequences the pipeline flush, waits for the pipeline to drain, then issues a PC redirect to mtvec.
- Also sequences the mret return to mepc. Sits between the exception sources and the fetch/PC-select stage.

Parameters:
- XLEN, 32, data/address width.
- NUM_SRC, 4, number of exception request sources; index 0 has the highest priority.
- MTVEC_RESET, 32'h0000_0100, reset value of mtvec.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- exc_valid_i  in  NUM_SRC  per-source exception request, level
- exc_cause_i  in  NUM_SRC*5  per-source cause code; source k occupies bits [5k+4:5k]
- exc_pc_i  in  NUM_SRC*XLEN  per-source faulting instruction PC
- exc_tval_i  in  NUM_SRC*XLEN  per-source trap value (e.g. faulting address)
- mret_i  in  1  mret retiring, single-cycle pulse
- pipe_empty_i  in  1  pipeline drained after flush
- redirect_ready_i  in  1  fetch accepts redirect
- csr_we_i  in  1  CSR write strobe
- csr_sel_i  in  2  CSR select: 0 mtvec, 1 mepc, 2 mcause, 3 mtval
- csr_wdata_i  in  XLEN  CSR write data
- exc_ack_o  out  NUM_SRC  one-hot pulse: source accepted
- flush_o  out  1  pipeline flush request
- redirect_valid_o  out  1  redirect request
- redirect_pc_o  out  XLEN  redirect target
- trap_busy_o  out  1  high whenever state != IDLE
- mtvec_o, mepc_o, mcause_o, mtval_o  out  XLEN each  CSR contents
- trap_count_o  out  32  accepted-trap counter (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous) puts all outputs and registers in these states:
  - state = IDLE
  - exc_ack_o, flush_o, redirect_valid_o, trap_busy_o, redirect_pc_o = 0
  - mepc, mcause, mtval = 0
  - mtvec = MTVEC_RESET
  - trap_count_o = 0
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE, any exc_valid_i bit high in cycle N:
  - The winner is the lowest set index.
  - At edge N+1: mepc = winner PC; mtval = winner tval; mcause = {27'b0, winner cause} (bit 31 = 0, exceptions only).
  - exc_ack_o[winner] = 1 for exactly one cycle (N+1). flush_o = 1. State goes to FLUSH with target = mtvec.
- IDLE, mret_i high and no exc_valid_i: state goes to FLUSH with target = mepc. CSRs unchanged, no ack.
- IDLE, exc_valid_i and mret_i in the same cycle: the exception wins and the mret is dropped.
- FLUSH:
  - flush_o held at 1 for at least 1 cycle.
  - When pipe_empty_i is sampled high in FLUSH, the next edge gives: flush_o = 0, redirect_valid_o = 1, redirect_pc_o = target, state goes to REDIRECT.
  - pipe_empty_i sampled in the first FLUSH cycle counts.
- REDIRECT:
  - redirect_valid_o and redirect_pc_o are held stable until redirect_ready_i is high at a clock edge.
  - That edge gives: redirect_valid_o = 0, state goes to IDLE.
  - Minimum end-to-end latency from request to back in IDLE is 3 edges.
- While state != IDLE:
  - New exc_valid_i and mret_i are ignored, with no ack. Sources keep requesting; their instructions are flushed.
  - Un-acked sources are not queued.
- CSR writes:
  - Accepted in any state at the clock edge.
  - A write to mtvec stores {wdata[XLEN-1:2], 2'b00}.
  - The redirect target is latched when entering FLUSH, so an mtvec write during FLUSH/REDIRECT does not change the in-flight redirect_pc_o.
  - If a CSR write and a trap capture hit the same register in the same cycle, the capture wins.
- Reset asserted mid-FLUSH or mid-REDIRECT: immediate return to IDLE, all outputs at reset values, no redirect issued.

Optional Feature:
- Macro: TRAP_SEQ_COUNT_EN.
- Defined: trap_count_o increments by 1 on each accepted exception (not on mret), saturating at 32'hFFFF_FFFF. It is cleared only by reset.
- Undefined: no counter register exists and trap_count_o is tied to 0.

Test Plan:
1. Reset check: hold reset_n low -> mtvec_o = 32'h100; all other outputs 0; trap_busy_o = 0.
2. Single misaligned trap:
   - Stimulus: exc_valid_i = 4'b0100, cause 4, pc 32'h2000, tval 32'h1003. pipe_empty_i rises 3 cycles later; redirect_ready_i = 1.
   - Response: exc_ack_o = 4'b0100 for one cycle; mepc = 32'h2000, mtval = 32'h1003, mcause = 4; flush_o high 4 cycles; one redirect to 32'h100; back to IDLE.
3. Priority: src1 (cause 2) and src3 (cause 4) both valid in the same cycle -> ack 4'b0010 only; mcause = 2; src3 never acked during the trap.
4. mret with stall:
   - Stimulus: mepc preset to 32'h2004; mret_i pulse; redirect_ready_i low for 2 cycles.
   - Response: redirect_valid_o held 3 cycles with pc 32'h2004 stable; mcause/mepc unchanged.
5. CSR write: write mtvec = 32'h0000_0303 -> mtvec_o = 32'h300. Then a later trap redirects to 32'h300. A same-cycle exception plus mret -> exception path taken.
6. Reset mid-operation: assert reset_n low while in REDIRECT -> redirect_valid_o = 0 immediately; state IDLE; trap_count_o = 0 (when TRAP_SEQ_COUNT_EN is defined).
